apb_master: RTL and testbench
=============================

# apb_master

Single-channel APB requester that converts a simple valid/ready command interface into APB SETUP/ACCESS transfers, and returns read data and error status on a one-cycle response strobe. It drives the APB slave side of the memory subsystem, replacing bench-driven Pselx/Penable sequencing with synthesizable logic. It supports slave wait states, error reporting, back-to-back transfers and a wait-state timeout.

## Interface
- ADDR_W, 5: APB address width.
- DATA_W, 32: APB data width.
- TIMEOUT, 16: maximum ACCESS cycles with Pready low before the master aborts the transfer; 0 disables the timeout.

- Pclk  in  1  clock; all logic on the rising edge.
- Prst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid at a rising edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_rdata  out  DATA_W  read data; 0 for writes and on timeout.
- rsp_err  out  1  Pslverr captured at completion, or 1 on timeout.
- Paddr  out  ADDR_W  APB address.
- Pselx  out  1  APB select.
- Penable  out  1  APB enable.
- Pwrite  out  1  APB direction.
- Pwdata  out  DATA_W  APB write data.
- Pready  in  1  slave ready.
- Pslverr  in  1  slave error; valid only when Pready is high in ACCESS.
- Prdata  in  DATA_W  slave read data; valid only when Pready is high in ACCESS.

## Operation
- FSM states:
  - IDLE: Pselx=0, Penable=0.
  - SETUP: Pselx=1, Penable=0.
  - ACCESS: Pselx=1, Penable=1.
- FSM transitions:
  - IDLE -> SETUP on cmd handshake.
  - SETUP -> ACCESS always.
  - ACCESS with Pready=1 -> SETUP if a new command handshakes in the same cycle; otherwise -> IDLE.
  - ACCESS with Pready=0 stays in ACCESS until the wait counter reaches TIMEOUT, then -> IDLE.
- cmd_ready = (state==IDLE) | (state==ACCESS & Pready). This is combinational from Pready. No other input-to-output combinational paths exist.
- On handshake the command is registered into Paddr, Pwrite and Pwdata. Paddr, Pwrite and Pwdata are stable throughout SETUP and ACCESS. They hold their last value in IDLE.
- Completion: when ACCESS is sampled with Pready=1, the next cycle has rsp_valid=1, rsp_err=Pslverr, and rsp_rdata=Prdata for reads (0 for writes).
- Wait counter: cleared on entry to ACCESS; increments on each ACCESS cycle with Pready=0.
- Timeout: at count==TIMEOUT (TIMEOUT>0) the transfer is abandoned. The next cycle has rsp_valid=1, rsp_err=1, rsp_rdata=0, and Pselx=0. cmd_ready is not asserted in the abort cycle.
- rsp_valid has no backpressure; the consumer must accept it.
- Reset: all outputs are 0, the FSM is in IDLE and the counter is 0. Reset mid-transfer drops Pselx/Penable on the next edge and produces no response.

## Timing
- Edge 0: handshake.
- Cycle 1: SETUP.
- Cycle 2: ACCESS.
- Zero-wait slave: Pready is sampled at edge 3; rsp_valid is high in cycle 3. Latency from handshake to rsp_valid is 3 cycles, plus N wait cycles.
- Back-to-back throughput is 2 cycles per transfer. Pselx stays high across transfers, and Penable drops for exactly one SETUP cycle.
- Timeout with TIMEOUT=T: the abort response appears T+3 cycles after the handshake.
- Penable never rises without a preceding SETUP cycle. Pselx never drops while Penable=1 except on abort or reset.

## Test plan
- Reset: assert Prst for 2 cycles mid-ACCESS -> next cycle Pselx=0, Penable=0, rsp_valid=0, all outputs 0, cmd_ready=1.
- Zero-wait write: addr=5'h0A, wdata=32'hDEADBEEF, Pready=1 -> SETUP in cycle 1 and ACCESS in cycle 2 with Paddr=0x0A and Pwrite=1; rsp_valid in cycle 3 with rsp_err=0 and rsp_rdata=0.
- Read with 2 wait states: addr=5'h0A, slave returns Prdata=32'hDEADBEEF on the third ACCESS cycle -> rsp_valid in cycle 5 with rsp_rdata=0xDEADBEEF; Paddr stable throughout.
- Slave error: read addr=5'h1F, Pready=1 with Pslverr=1 -> rsp_err=1 for exactly one cycle; the next transfer has rsp_err=0.
- Back-to-back: cmd_valid held with 4 writes to addr 0..3, zero-wait slave -> Pselx continuously high, Penable toggling 0/1, 4 rsp_valid pulses 2 cycles apart.
- Timeout: TIMEOUT=4, Pready tied 0 -> after 4 ACCESS cycles rsp_valid=1, rsp_err=1, rsp_rdata=0, Pselx=0; the following command proceeds normally.

Source files
------------

// File: rtl/apb_master.sv
// apb_master
//   Single-channel APB requester. Commands arrive on a valid/ready interface
//   and are issued as APB SETUP/ACCESS transfers. Each transfer finishes with
//   a one-cycle response strobe carrying read data and error status. A
//   wait-state timeout abandons transfers whose slave never asserts Pready.
//
// Ports
//   Pclk, Prst        clock (rising edge) and synchronous active-high reset
//   cmd_valid/ready   command handshake; cmd_write, cmd_addr, cmd_wdata fields
//   rsp_valid         one-cycle completion strobe (no backpressure)
//   rsp_rdata/err     read data (0 for writes/timeout) and error flag
//   Paddr .. Pwdata   APB requester outputs
//   Pready, Pslverr,
//   Prdata            APB completer inputs, sampled only in ACCESS
module apb_master #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              Pclk,
  input  logic              Prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] Paddr,
  output logic              Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [DATA_W-1:0] Pwdata,
  input  logic              Pready,
  input  logic              Pslverr,
  input  logic [DATA_W-1:0] Prdata
);

  // Counter only needs to reach TIMEOUT; keep one bit when the timeout is off.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

  logic handshake;
  logic timed_out;

  // The only combinational input-to-output path: a completing ACCESS cycle
  // can accept the next command so back-to-back transfers take 2 cycles.
  assign cmd_ready = (state_q == ST_IDLE) || ((state_q == ST_ACCESS) && Pready);
  assign handshake = cmd_valid && cmd_ready;
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (handshake) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = '0;
      end
      ST_ACCESS: begin
        if (Pready) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = Pslverr;
          rsp_rdata_d = pwrite_q ? '0 : Prdata;
          state_d     = handshake ? ST_SETUP : ST_IDLE;
        end else if (timed_out) begin
          // Abandon the transfer; cmd_ready is low here since Pready is low.
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = ST_IDLE;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Command fields are captured only on handshake and hold otherwise.
    if (handshake) begin
      paddr_d  = cmd_addr;
      pwrite_d = cmd_write;
      pwdata_d = cmd_wdata;
    end
  end

  always_ff @(posedge Pclk) begin
    if (Prst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign Pselx     = (state_q != ST_IDLE);
  assign Penable   = (state_q == ST_ACCESS);
  assign Paddr     = paddr_q;
  assign Pwrite    = pwrite_q;
  assign Pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master
//   Directed bench for apb_master (TIMEOUT=4). A transaction-level model turns
//   a command table into per-cycle expected APB/response waveforms using the
//   transfer latency rules; a compare process checks every cycle, plus a table
//   of hand-computed literal expectations and a mid-ACCESS reset sequence.
module tb_apb_master;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int NC = 52;
  localparam int NCMD = 11;
  localparam int NL = 34;

  logic          Pclk, Prst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] Paddr;
  logic          Pselx, Penable, Pwrite;
  logic [DW-1:0] Pwdata;
  logic          Pready, Pslverr;
  logic [DW-1:0] Prdata;

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .Pclk(Pclk), .Prst(Prst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Paddr(Paddr), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Pwdata(Pwdata), .Pready(Pready), .Pslverr(Pslverr), .Prdata(Prdata)
  );

  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  // waits < 0 means the slave never answers (timeout case).
  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic [DW-1:0] rdata;
    bit            err;
    int            delay;
  } cmd_t;

  typedef struct {
    int            cyc;
    int            sig;
    logic [DW-1:0] val;
  } lit_t;

  cmd_t cmds[NCMD];
  lit_t lits[NL];

  // Stimulus timeline
  bit            s_valid[NC], s_write[NC], s_pready[NC], s_pslverr[NC];
  logic [AW-1:0] s_addr[NC];
  logic [DW-1:0] s_wdata[NC], s_prdata[NC];
  // Expected timeline
  bit            e_psel[NC], e_pen[NC], e_ready[NC], e_rv[NC], e_rerr[NC], e_pwrite[NC];
  bit            e_last[NC];
  logic [AW-1:0] e_paddr[NC];
  logic [DW-1:0] e_rdata[NC], e_pwdata[NC];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit tl_on    = 1'b0;
  int rchk     = 0;   // 1: expect ACCESS of reset-phase read, 2: expect reset state

  task automatic chk(input string name, input int c, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, c, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] sig_val(input int s);
    case (s)
      0: sig_val = DW'(rsp_valid);
      1: sig_val = DW'(rsp_err);
      2: sig_val = rsp_rdata;
      3: sig_val = DW'(Pselx);
      4: sig_val = DW'(Penable);
      5: sig_val = DW'(cmd_ready);
      6: sig_val = DW'(Paddr);
      default: sig_val = DW'(Pwrite);
    endcase
  endfunction

  // Compare process
  always @(negedge Pclk) begin
    if (tl_on) begin
      chk("psel",   cyc, DW'(Pselx),     DW'(e_psel[cyc]));
      chk("penable",cyc, DW'(Penable),   DW'(e_pen[cyc]));
      chk("ready",  cyc, DW'(cmd_ready), DW'(e_ready[cyc]));
      chk("rvalid", cyc, DW'(rsp_valid), DW'(e_rv[cyc]));
      chk("paddr",  cyc, DW'(Paddr),     DW'(e_paddr[cyc]));
      chk("pwrite", cyc, DW'(Pwrite),    DW'(e_pwrite[cyc]));
      chk("pwdata", cyc, Pwdata,         e_pwdata[cyc]);
      if (e_rv[cyc]) begin
        chk("rerr",   cyc, DW'(rsp_err), DW'(e_rerr[cyc]));
        chk("rrdata", cyc, rsp_rdata,    e_rdata[cyc]);
      end
      for (int i = 0; i < NL; i++)
        if (lits[i].cyc == cyc) chk($sformatf("lit%0d", i), cyc, sig_val(lits[i].sig), lits[i].val);
      if (rsp_valid)
        $display("cycle %0d response err=%0d rdata=%h", cyc, rsp_err, rsp_rdata);
    end
    if (rchk == 1) begin
      chk("rst_pre_psel", -1, DW'(Pselx),   DW'(1));
      chk("rst_pre_pen",  -1, DW'(Penable), DW'(1));
      chk("rst_pre_addr", -1, DW'(Paddr),   DW'(5'h12));
    end else if (rchk == 2) begin
      chk("rst_psel",  -1, DW'(Pselx),     '0);
      chk("rst_pen",   -1, DW'(Penable),   '0);
      chk("rst_rv",    -1, DW'(rsp_valid), '0);
      chk("rst_rerr",  -1, DW'(rsp_err),   '0);
      chk("rst_rdata", -1, rsp_rdata,      '0);
      chk("rst_paddr", -1, DW'(Paddr),     '0);
      chk("rst_pwr",   -1, DW'(Pwrite),    '0);
      chk("rst_pwd",   -1, Pwdata,         '0);
      chk("rst_ready", -1, DW'(cmd_ready), DW'(1));
    end
  end

  initial begin
    int prev_h, free_c, v, h, last, rsp;

    //              wr    addr   wdata         waits rdata         err delay
    cmds[0]  = '{1'b1, 5'h0A, 32'hDEADBEEF,  0, 32'h11111111, 1'b0, 1};
    cmds[1]  = '{1'b0, 5'h0A, 32'h0,         2, 32'hDEADBEEF, 1'b0, 3};
    cmds[2]  = '{1'b0, 5'h1F, 32'h0,         0, 32'h12345678, 1'b1, 6};
    cmds[3]  = '{1'b0, 5'h01, 32'h0,         0, 32'hA5A5A5A5, 1'b0, 3};
    cmds[4]  = '{1'b1, 5'h00, 32'h00001000,  0, 32'h22222222, 1'b0, 3};
    cmds[5]  = '{1'b1, 5'h01, 32'h00001001,  0, 32'h33333333, 1'b0, 0};
    cmds[6]  = '{1'b1, 5'h02, 32'h00001002,  0, 32'h44444444, 1'b0, 0};
    cmds[7]  = '{1'b1, 5'h03, 32'h00001003,  0, 32'h55555555, 1'b0, 0};
    cmds[8]  = '{1'b0, 5'h15, 32'h0,        -1, 32'h66666666, 1'b0, 4};
    cmds[9]  = '{1'b1, 5'h07, 32'hCAFEF00D,  1, 32'h77777777, 1'b0, 0};
    cmds[10] = '{1'b1, 5'h03, 32'h0BADCAFE,  0, 32'hFFFF0000, 1'b1, 5};

    lits[0]  = '{0, 5, 1};           lits[1]  = '{0, 3, 0};
    lits[2]  = '{3, 6, 32'h0A};      lits[3]  = '{3, 7, 1};
    lits[4]  = '{3, 4, 1};           lits[5]  = '{2, 4, 0};
    lits[6]  = '{2, 3, 1};           lits[7]  = '{4, 0, 1};
    lits[8]  = '{4, 1, 0};           lits[9]  = '{4, 2, 0};
    lits[10] = '{10, 0, 1};          lits[11] = '{10, 2, 32'hDEADBEEF};
    lits[12] = '{8, 6, 32'h0A};      lits[13] = '{15, 1, 1};
    lits[14] = '{16, 0, 0};          lits[15] = '{19, 1, 0};
    lits[16] = '{19, 0, 1};          lits[17] = '{23, 3, 1};
    lits[18] = '{23, 4, 0};          lits[19] = '{24, 4, 1};
    lits[20] = '{25, 0, 1};          lits[21] = '{27, 0, 1};
    lits[22] = '{29, 0, 1};          lits[23] = '{37, 5, 0};
    lits[24] = '{38, 0, 1};          lits[25] = '{38, 1, 1};
    lits[26] = '{38, 2, 0};          lits[27] = '{38, 3, 0};
    lits[28] = '{42, 0, 1};          lits[29] = '{47, 1, 1};
    lits[30] = '{47, 2, 0};          lits[31] = '{9, 0, 0};
    lits[32] = '{24, 0, 0};          lits[33] = '{37, 3, 1};

    // Background: junk on idle command fields and slave data lines.
    for (int c = 0; c < NC; c++) begin
      s_valid[c]   = 1'b0;
      s_write[c]   = c[1];
      s_addr[c]    = c[4:0];
      s_wdata[c]   = 32'h5A5A0000 + c;
      s_pready[c]  = 1'b0;
      s_pslverr[c] = c[0];
      s_prdata[c]  = 32'hBAD00000 + c;
      e_psel[c] = 0; e_pen[c] = 0; e_rv[c] = 0; e_rerr[c] = 0; e_last[c] = 0;
      e_rdata[c] = '0; e_paddr[c] = '0; e_pwrite[c] = 0; e_pwdata[c] = '0;
    end

    // Transaction model: a command handshakes at max(first valid cycle, first
    // cycle the master can accept). SETUP follows, then ACCESS for waits+1
    // cycles; the response appears the cycle after the last ACCESS cycle.
    prev_h = -1;
    free_c = 0;
    for (int k = 0; k < NCMD; k++) begin
      v = prev_h + 1 + cmds[k].delay;
      h = (v > free_c) ? v : free_c;
      for (int c = v; c <= h; c++) begin
        s_valid[c] = 1'b1; s_write[c] = cmds[k].wr;
        s_addr[c] = cmds[k].addr; s_wdata[c] = cmds[k].wdata;
      end
      if (cmds[k].waits >= 0) begin
        last = h + 2 + cmds[k].waits;
        rsp  = last + 1;
        s_pready[last] = 1'b1; s_prdata[last] = cmds[k].rdata; s_pslverr[last] = cmds[k].err;
        e_rerr[rsp]  = cmds[k].err;
        e_rdata[rsp] = cmds[k].wr ? '0 : cmds[k].rdata;
        e_last[last] = 1'b1;
        free_c = last;
      end else begin
        last = h + 2 + TO;
        rsp  = last + 1;
        e_rerr[rsp] = 1'b1; e_rdata[rsp] = '0;
        free_c = rsp;
      end
      e_rv[rsp] = 1'b1;
      for (int c = h + 1; c <= last; c++) e_psel[c] = 1'b1;
      for (int c = h + 2; c <= last; c++) e_pen[c] = 1'b1;
      for (int c = h + 1; c < NC; c++) begin
        e_paddr[c] = cmds[k].addr; e_pwrite[c] = cmds[k].wr; e_pwdata[c] = cmds[k].wdata;
      end
      prev_h = h;
    end
    for (int c = 0; c < NC; c++) e_ready[c] = !e_psel[c] || e_last[c];

    // Reset, then run the timeline.
    Prst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    Pready = 0; Pslverr = 0; Prdata = '0;
    repeat (3) @(posedge Pclk);
    #1 Prst = 1'b0;
    for (int c = 0; c < NC; c++) begin
      cyc = c;
      cmd_valid = s_valid[c]; cmd_write = s_write[c]; cmd_addr = s_addr[c];
      cmd_wdata = s_wdata[c]; Pready = s_pready[c]; Pslverr = s_pslverr[c];
      Prdata = s_prdata[c];
      tl_on = 1'b1;
      @(posedge Pclk); #1;
    end
    tl_on = 1'b0;

    // Reset in the middle of a stalled ACCESS.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h12; cmd_wdata = 32'h0;
    Pready = 1'b0; Pslverr = 1'b0;
    @(posedge Pclk); #1 cmd_valid = 1'b0;          // SETUP
    @(posedge Pclk); #1 rchk = 1;                  // ACCESS, count 0
    @(posedge Pclk); #1 Prst = 1'b1;               // ACCESS, reset asserted
    @(posedge Pclk); #1 rchk = 2;                  // reset state, Prst still high
    @(posedge Pclk); #1 Prst = 1'b0;
    repeat (3) begin
      @(posedge Pclk); #1;
    end
    rchk = 0;
    #10;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
